// File: rtl/vending_pkg.sv
// Shared constants for the vending controller: widths, FSM state codes and
// the item price table that the external pricing datapath implements.
package vending_pkg;
  localparam int MONEY_W   = 4;
  localparam int STOCK_W   = 3;
  localparam int NUM_ITEMS = 4;

  localparam logic [1:0] ST_IDLE     = 2'd0;
  localparam logic [1:0] ST_CHECK    = 2'd1;
  localparam logic [1:0] ST_DISPENSE = 2'd2;
  localparam logic [1:0] ST_CHANGE   = 2'd3;

  function automatic int price(input logic [1:0] code);
    case (code)
      2'd0:    price = 2;
      2'd1:    price = 3;
      2'd2:    price = 5;
      default: price = 7;
    endcase
  endfunction
endpackage

// File: rtl/vending_if.sv
// Customer, restock, datapath and dispense signals of the vending controller.
// slave is the controller side, master the environment side.
interface vending_if #(parameter int MONEY_W = 4, parameter int STOCK_W = 3);
  logic               coin_valid;
  logic [MONEY_W-1:0] coin_value;
  logic               sel_valid;
  logic [1:0]         sel_code;
  logic [2:0]         sel_count;
  logic               cancel;
  logic               restock_valid;
  logic [1:0]         restock_code;
  logic [STOCK_W-1:0] restock_qty;
  logic [1:0]         dp_code;
  logic [2:0]         dp_count;
  logic [MONEY_W-1:0] dp_money;
  logic               dp_posibility;
  logic [MONEY_W-1:0] dp_remaining;
  logic               dispense_valid;
  logic [1:0]         dispense_code;
  logic [2:0]         dispense_count;
  logic               change_valid;
  logic [MONEY_W-1:0] change_amount;
  logic               coin_return;
  logic               sel_error;
  logic               busy;

  modport slave (
    input  coin_valid, coin_value, sel_valid, sel_code, sel_count, cancel,
           restock_valid, restock_code, restock_qty, dp_posibility, dp_remaining,
    output dp_code, dp_count, dp_money, dispense_valid, dispense_code,
           dispense_count, change_valid, change_amount, coin_return, sel_error, busy
  );
  modport master (
    output coin_valid, coin_value, sel_valid, sel_code, sel_count, cancel,
           restock_valid, restock_code, restock_qty, dp_posibility, dp_remaining,
    input  dp_code, dp_count, dp_money, dispense_valid, dispense_code,
           dispense_count, change_valid, change_amount, coin_return, sel_error, busy
  );
endinterface

// File: rtl/vending_stock.sv
// Per-item stock counters: saturating restock, dispense decrement (both may
// hit the same item in one cycle) and an availability compare.
module vending_stock
  import vending_pkg::*;
#(
  parameter int STOCK_W    = 3,
  parameter int STOCK_INIT = 5,
  parameter int STOCK_MAX  = 7
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               restock_valid,
  input  logic [1:0]         restock_code,
  input  logic [STOCK_W-1:0] restock_qty,
  input  logic               dec_valid,
  input  logic [1:0]         dec_code,
  input  logic [2:0]         dec_count,
  input  logic [1:0]         chk_code,
  input  logic [2:0]         chk_count,
  output logic               stock_ok
);
  localparam int SW = STOCK_W + 4;

  logic [NUM_ITEMS-1:0][STOCK_W-1:0] stock, nxt;
  logic [NUM_ITEMS-1:0][SW-1:0]      sum;

  // Decrement never exceeds stock + restock: the CHECK compare guarantees it.
  always_comb begin
    sum = '0;
    nxt = '0;
    for (int i = 0; i < NUM_ITEMS; i++) begin
      sum[i] = SW'(stock[i])
             + ((restock_valid && restock_code == 2'(i)) ? SW'(restock_qty) : SW'(0))
             - ((dec_valid && dec_code == 2'(i)) ? SW'(dec_count) : SW'(0));
      nxt[i] = (sum[i] > SW'(STOCK_MAX)) ? STOCK_W'(STOCK_MAX) : sum[i][STOCK_W-1:0];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_ITEMS; i++) stock[i] <= STOCK_W'(STOCK_INIT);
    end else begin
      stock <= nxt;
    end
  end

  assign stock_ok = SW'(stock[chk_code]) >= SW'(chk_count);
endmodule

// File: rtl/vending_controller.sv
// Vending sequencer: credit accumulation, selection latch, one-cycle pricing
// check against the external datapath, dispense and change sequencing.
module vending_controller
  import vending_pkg::*;
#(
  parameter int MONEY_W    = 4,
  parameter int STOCK_W    = 3,
  parameter int STOCK_INIT = 5,
  parameter int STOCK_MAX  = 7
) (
  input  logic     clk,
  input  logic     rst_n,
  vending_if.slave bus
);
  logic [1:0]         state;
  logic [MONEY_W-1:0] credit, chg_lat;
  logic [MONEY_W:0]   coin_sum;
  logic               stock_ok;

  assign coin_sum     = {1'b0, credit} + {1'b0, bus.coin_value};
  assign bus.dp_money = credit;
  assign bus.busy     = (state != ST_IDLE);

  vending_stock #(
    .STOCK_W(STOCK_W), .STOCK_INIT(STOCK_INIT), .STOCK_MAX(STOCK_MAX)
  ) u_stock (
    .clk          (clk),
    .rst_n        (rst_n),
    .restock_valid(bus.restock_valid),
    .restock_code (bus.restock_code),
    .restock_qty  (bus.restock_qty),
    .dec_valid    (state == ST_DISPENSE),
    .dec_code     (bus.dp_code),
    .dec_count    (bus.dp_count),
    .chk_code     (bus.dp_code),
    .chk_count    (bus.dp_count),
    .stock_ok     (stock_ok)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state              <= ST_IDLE;
      credit             <= '0;
      chg_lat            <= '0;
      bus.dp_code        <= '0;
      bus.dp_count       <= '0;
      bus.dispense_valid <= 1'b0;
      bus.dispense_code  <= '0;
      bus.dispense_count <= '0;
      bus.change_valid   <= 1'b0;
      bus.change_amount  <= '0;
      bus.coin_return    <= 1'b0;
      bus.sel_error      <= 1'b0;
    end else begin
      bus.dispense_valid <= 1'b0;
      bus.change_valid   <= 1'b0;
      bus.coin_return    <= 1'b0;
      bus.sel_error      <= 1'b0;
      if (state != ST_IDLE && bus.coin_valid) bus.coin_return <= 1'b1;
      case (state)
        ST_IDLE: begin
          // A coin arriving with an effective cancel is handed straight back.
          if (bus.cancel && credit != '0) begin
            bus.change_valid  <= 1'b1;
            bus.change_amount <= credit;
            credit            <= '0;
            if (bus.coin_valid) bus.coin_return <= 1'b1;
          end else if (bus.coin_valid) begin
            if (!coin_sum[MONEY_W]) credit <= coin_sum[MONEY_W-1:0];
            else                    bus.coin_return <= 1'b1;
          end
          if (bus.sel_valid && !bus.cancel) begin
            bus.dp_code  <= bus.sel_code;
            bus.dp_count <= bus.sel_count;
            state        <= ST_CHECK;
          end
        end
        ST_CHECK: begin
          if (bus.dp_posibility && bus.dp_count != '0 && stock_ok) begin
            chg_lat <= bus.dp_remaining;
            state   <= ST_DISPENSE;
          end else begin
            bus.sel_error <= 1'b1;
            state         <= ST_IDLE;
          end
        end
        ST_DISPENSE: begin
          bus.dispense_valid <= 1'b1;
          bus.dispense_code  <= bus.dp_code;
          bus.dispense_count <= bus.dp_count;
          credit             <= '0;
          state              <= (chg_lat != '0) ? ST_CHANGE : ST_IDLE;
        end
        default: begin
          bus.change_valid  <= 1'b1;
          bus.change_amount <= chg_lat;
          state             <= ST_IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_vending_controller.sv
// Scoreboard bench: each stimulus task pushes the output pulses it should cause
// (kind, data, cycle) and a negedge monitor pops and compares them.
module tb_vending_controller;
  import vending_pkg::*;

  localparam int EV_DISP = 1, EV_CHG = 2, EV_COIN = 3, EV_SERR = 4;

  typedef struct {int cyc; int kind; int data;} ev_t;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  vending_if #(.MONEY_W(4), .STOCK_W(3)) bus();

  vending_controller #(.MONEY_W(4), .STOCK_W(3), .STOCK_INIT(5), .STOCK_MAX(7)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus)
  );

  ev_t sb[$];
  int  cyc = 0;
  int  n_vec = 0, n_err = 0;
  int  m_credit;
  int  m_stock[4];
  int  dp_cost;

  always @(posedge clk) cyc <= cyc + 1;

  // Pricing datapath stub
  always_comb begin
    dp_cost           = price(bus.dp_code) * int'(bus.dp_count);
    bus.dp_posibility = int'(bus.dp_money) >= dp_cost;
    bus.dp_remaining  = bus.dp_posibility ? 4'(int'(bus.dp_money) - dp_cost) : 4'd0;
  end

  task automatic chk(input string tag, input int act, input int exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  task automatic push(input int c, input int k, input int d);
    ev_t e;
    e.cyc = c; e.kind = k; e.data = d;
    sb.push_back(e);
  endtask

  task automatic observe(input int kind, input int data);
    ev_t e;
    if (sb.size() == 0) chk("unexpected_pulse", kind, 0);
    else begin
      e = sb.pop_front();
      chk("ev_kind", kind, e.kind);
      chk("ev_data", data, e.data);
      chk("ev_cycle", cyc, e.cyc);
    end
  endtask

  always @(negedge clk) begin
    if (bus.dispense_valid) observe(EV_DISP, int'({bus.dispense_code, bus.dispense_count}));
    if (bus.change_valid)   observe(EV_CHG, int'(bus.change_amount));
    if (bus.coin_return)    observe(EV_COIN, 0);
    if (bus.sel_error)      observe(EV_SERR, 0);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) step();
  endtask

  task automatic coin(input int v);
    bus.coin_valid = 1'b1; bus.coin_value = 4'(v);
    step();
    bus.coin_valid = 1'b0;
    if (m_credit + v <= 15) m_credit += v;
    else push(cyc, EV_COIN, 0);
  endtask

  task automatic cancel_req();
    bus.cancel = 1'b1;
    step();
    bus.cancel = 1'b0;
    if (m_credit != 0) begin
      push(cyc, EV_CHG, m_credit);
      m_credit = 0;
    end
  endtask

  task automatic sel(input int c, input int n, output int e);
    int cost;
    bus.sel_valid = 1'b1; bus.sel_code = 2'(c); bus.sel_count = 3'(n);
    step();
    bus.sel_valid = 1'b0;
    e = cyc;
    cost = price(2'(c)) * n;
    if (n != 0 && m_credit >= cost && m_stock[c] >= n) begin
      push(e + 2, EV_DISP, c * 8 + n);
      if (m_credit - cost != 0) push(e + 3, EV_CHG, m_credit - cost);
      m_stock[c] -= n;
      m_credit = 0;
    end else push(e + 1, EV_SERR, 0);
  endtask

  task automatic restock(input int c, input int q);
    bus.restock_valid = 1'b1; bus.restock_code = 2'(c); bus.restock_qty = 3'(q);
    step();
    bus.restock_valid = 1'b0;
    m_stock[c] = (m_stock[c] + q > 7) ? 7 : m_stock[c] + q;
  endtask

  task automatic check_state(input string tag);
    chk({tag, "_credit"}, int'(bus.dp_money), m_credit);
    chk({tag, "_busy"}, int'(bus.busy), 0);
    for (int i = 0; i < 4; i++)
      chk($sformatf("%s_stock%0d", tag, i), int'(dut.u_stock.stock[i]), m_stock[i]);
  endtask

  task automatic model_reset();
    m_credit = 0;
    for (int i = 0; i < 4; i++) m_stock[i] = 5;
  endtask

  task automatic check_quiet(input string tag);
    chk({tag, "_outs"}, int'({bus.dispense_valid, bus.change_valid, bus.coin_return,
                              bus.sel_error, bus.busy}), 0);
    chk({tag, "_chg_amt"}, int'(bus.change_amount), 0);
    chk({tag, "_money"}, int'(bus.dp_money), 0);
  endtask

  initial begin
    int e;
    rst_n = 1'b0;
    bus.coin_valid = 0; bus.coin_value = 0; bus.sel_valid = 0; bus.sel_code = 0;
    bus.sel_count = 0; bus.cancel = 0; bus.restock_valid = 0; bus.restock_code = 0;
    bus.restock_qty = 0;
    model_reset();
    idle(3);
    check_quiet("reset");
    check_state("reset");
    rst_n = 1'b1;
    idle(2);

    // Exact-fit credit 15, buy code1 x1 with change 12
    coin(5); coin(5); coin(5);
    chk("credit15", int'(bus.dp_money), 15);
    sel(1, 1, e);
    idle(5);
    chk("stock1_after_buy", int'(dut.u_stock.stock[1]), 4);
    check_state("buy1");

    // Overflowing coin is returned, then refund
    coin(5); coin(5); coin(5); coin(1);
    chk("credit_hold", int'(bus.dp_money), 15);
    cancel_req();
    idle(2);
    check_state("refund15");

    // Insufficient credit: sel_error, credit kept, then cancel refunds it
    coin(4);
    sel(3, 1, e);
    idle(3);
    chk("credit_kept", int'(bus.dp_money), 4);
    cancel_req();
    idle(2);
    check_state("refund4");

    // Stock exhaustion on code0 and saturating restock
    for (int k = 0; k < 3; k++) begin
      cancel_req();
      coin(5); coin(5); coin(5);
      sel(0, 3, e);
      idle(5);
      chk($sformatf("stock0_round%0d", k), int'(dut.u_stock.stock[0]), m_stock[0]);
    end
    chk("stock0_exhausted", int'(dut.u_stock.stock[0]), 2);
    restock(0, 7);
    chk("stock0_saturated", int'(dut.u_stock.stock[0]), 7);
    cancel_req();
    idle(2);
    check_state("restock");

    // Zero-change buy; coin and same-item restock land in DISPENSE
    coin(5); coin(1);
    sel(0, 3, e);
    step();
    bus.coin_valid = 1'b1; bus.coin_value = 4'd2;
    bus.restock_valid = 1'b1; bus.restock_code = 2'd0; bus.restock_qty = 3'd2;
    step();
    bus.coin_valid = 1'b0; bus.restock_valid = 1'b0;
    push(cyc, EV_COIN, 0);
    m_stock[0] = (m_stock[0] + 2 > 7) ? 7 : m_stock[0] + 2;
    idle(4);
    check_state("disp_overlap");

    // Reset while in CHECK: everything clears, no pulses follow
    coin(5); coin(5); coin(5);
    bus.sel_valid = 1'b1; bus.sel_code = 2'd1; bus.sel_count = 3'd1;
    step();
    bus.sel_valid = 1'b0;
    chk("busy_in_check", int'(bus.busy), 1);
    rst_n = 1'b0;
    #1;
    model_reset();
    check_quiet("midreset");
    check_state("midreset");
    idle(2);
    rst_n = 1'b1;
    idle(6);
    check_state("post_reset");

    chk("sb_drained", sb.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/vending_controller.md
Name: vending_controller

Overview:
- Clocked sequencer wrapped around the combinational `vendingmachine` pricing datapath.
  - Datapath inputs: code[1:0], count[2:0], money[3:0]. Outputs: posibility, remaining[3:0].
- Accumulates inserted coins into a credit register and latches an item selection.
- Presents code/count/credit to the datapath for one evaluation cycle, then dispenses and returns change, or rejects.
- Keeps a per-item stock counter, decrements it on dispense, and accepts restock requests.

Parameters:
- MONEY_W, 4, width of credit, coin value and change; must match datapath money width.
- STOCK_W, 3, width of each per-item stock counter.
- STOCK_INIT, 5, stock value of every item after reset.
- STOCK_MAX, 7, saturation ceiling for restock; must satisfy STOCK_MAX <= 2^STOCK_W-1.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- coin_valid  in  1  one-cycle coin insertion strobe.
- coin_value  in  MONEY_W  value of the inserted coin.
- sel_valid  in  1  one-cycle selection strobe.
- sel_code  in  2  item code.
- sel_count  in  3  quantity requested.
- cancel  in  1  refund request.
- restock_valid  in  1  restock strobe.
- restock_code  in  2  item to restock.
- restock_qty  in  STOCK_W  quantity to add.
- dp_code  out  2  to datapath code.
- dp_count  out  3  to datapath count.
- dp_money  out  MONEY_W  to datapath money; always equals the credit register.
- dp_posibility  in  1  from datapath.
- dp_remaining  in  MONEY_W  from datapath.
- dispense_valid  out  1  one-cycle dispense pulse.
- dispense_code  out  2  item dispensed; valid with dispense_valid.
- dispense_count  out  3  quantity dispensed; valid with dispense_valid.
- change_valid  out  1  one-cycle change pulse.
- change_amount  out  MONEY_W  change or refund amount; valid with change_valid.
- coin_return  out  1  one-cycle pulse: coin rejected (value returned physically).
- sel_error  out  1  one-cycle pulse: selection rejected.
- busy  out  1  high whenever state != IDLE.

Behaviour:
- Reset (rst_n low, asynchronous):
  - State IDLE, credit 0, every stock[i] = STOCK_INIT.
  - Selection registers 0; all pulse outputs 0; change_amount 0; busy 0.
  - Reset mid-transaction discards credit without issuing change.
- States: IDLE, CHECK, DISPENSE, CHANGE. All outputs are registered except dp_money (the credit register) and busy (state decode).
- IDLE, priority order within one cycle:
  1. cancel: if credit != 0, change_valid=1 with change_amount=credit next cycle, and credit<=0. A sel_valid in the same cycle is ignored. If credit == 0, cancel is a no-op.
  2. coin_valid: if credit+coin_value <= 2^MONEY_W-1, credit += coin_value; otherwise credit is unchanged and coin_return pulses next cycle.
  3. sel_valid (no cancel): latch sel_code/sel_count into dp_code/dp_count and go to CHECK. A coin accepted in the same cycle counts toward this purchase.
- CHECK (exactly 1 cycle): sample dp_posibility and dp_remaining.
  - Accept when dp_posibility=1, dp_count != 0 and stock[dp_code] >= dp_count. Then latch remaining into the change register and go to DISPENSE.
  - Otherwise sel_error pulses next cycle, credit is kept, and the state returns to IDLE.
- DISPENSE (1 cycle):
  - dispense_valid=1 with dispense_code/count next cycle.
  - stock[dp_code] -= dp_count; credit <= 0.
  - Go to CHANGE if latched remaining != 0, else to IDLE.
- CHANGE (1 cycle): change_valid=1 with change_amount = latched remaining next cycle; go to IDLE.
- Coin in any non-IDLE state: not credited; coin_return pulses. sel_valid and cancel outside IDLE are ignored.
- Restock is accepted in any state: stock[code] = min(stock+qty, STOCK_MAX). If it coincides with the DISPENSE decrement on the same code, the result is min(stock - count + qty, STOCK_MAX).
- Latency: sel_valid at cycle N gives sel_error at N+2, or dispense_valid at N+3 and change_valid at N+4.
- Datapath contract (used by the bench model): prices {code0:2, code1:3, code2:5, code3:7}.
  - posibility = (money >= price*count); remaining = money - price*count when possible, else 0.

Decomposition:
- Package vending_pkg holds:
  - state enum {IDLE, CHECK, DISPENSE, CHANGE};
  - constants MONEY_W, STOCK_W, NUM_ITEMS=4;
  - the price table, for the bench model only.
- One sub-module, vending_stock: 4-entry stock counter array with saturating restock, decrement port and a stock_ok compare output. The FSM and credit logic stay in the top level.

Test Plan:
- Coins 5+5+5 (credit 15), select code1 count1 -> sel_error 0; dispense_valid at sel+3 (code1, count1); change_valid at sel+4 with 12; stock[1]=4; credit 0.
- Credit 15, coin 1 -> coin_return pulse, credit stays 15.
- Credit 4, select code3 count1 -> sel_error at sel+2, credit remains 4. Then cancel -> change_valid with 4, credit 0.
- Credit 15, select code0 count3 three times (buying each time from fresh 15 credit) -> stock[0] goes 5->2->2: second buy passes only if stock >= 3. Third buy gives sel_error. Restock code0 qty 7 -> stock saturates at 7.
- Credit 6, select code0 count3 -> dispense with no change_valid (remaining 0). Coin during DISPENSE -> coin_return, credit 0.
- Assert rst_n low during CHECK -> all outputs 0 immediately, stock back to 5, no dispense or change pulse afterwards.
